// File: rtl/eeprom_fetch.sv
// Burst reader for a parallel EEPROM: fetches BYTES consecutive bytes per word,
// assembles them little-endian and presents each word on a valid/ready handshake.
module eeprom_fetch #(
  parameter int DEPTH       = 2,
  parameter int WIDTH       = 8,
  parameter int BYTES       = 2,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                   CLK,
  input  logic                   N_RST,
  input  logic                   START,
  input  logic [DEPTH-1:0]       BASE_ADDR,
  input  logic [7:0]             COUNT,
  input  logic                   ABORT,
  output logic [DEPTH-1:0]       ROM_ADDR,
  output logic                   ROM_N_OE,
  input  logic [WIDTH-1:0]       ROM_DATA,
  output logic [WIDTH*BYTES-1:0] OUT_WORD,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic                   BUSY,
  output logic                   DONE
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    PRESENT = 2'd2,
    FINISH  = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);
  localparam logic [1:0] BYTE_LAST = 2'(BYTES - 1);

  state_t                 state_q, state_d;
  logic [DEPTH-1:0]       addr_q, addr_d;
  logic [7:0]             count_q, count_d;
  logic [1:0]             byte_q, byte_d;
  logic [3:0]             wait_q, wait_d;
  logic [WIDTH*BYTES-1:0] word_q, word_d;

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      count_q <= '0;
      byte_q  <= '0;
      wait_q  <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      byte_q  <= byte_d;
      wait_q  <= wait_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    byte_d  = byte_q;
    wait_d  = wait_q;
    word_d  = word_q;
    if (ABORT) begin
      state_d = IDLE;
      byte_d  = '0;
      wait_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (START) begin
            addr_d  = BASE_ADDR;
            count_d = COUNT;
            byte_d  = '0;
            wait_d  = '0;
            state_d = (COUNT != 8'd0) ? READ : FINISH;
          end
        end
        READ: begin
          // Data is only trusted on the edge closing the last access cycle.
          if (wait_q == WAIT_LAST) begin
            for (int k = 0; k < BYTES; k++) begin
              if (byte_q == 2'(k)) word_d[WIDTH*k +: WIDTH] = ROM_DATA;
            end
            addr_d = addr_q + DEPTH'(1);
            wait_d = '0;
            if (byte_q == BYTE_LAST) begin
              byte_d  = '0;
              state_d = PRESENT;
            end else begin
              byte_d = byte_q + 2'd1;
            end
          end else begin
            wait_d = wait_q + 4'd1;
          end
        end
        PRESENT: begin
          if (OUT_READY) begin
            count_d = count_q - 8'd1;
            state_d = (count_q == 8'd1) ? FINISH : READ;
          end
        end
        FINISH:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign ROM_ADDR  = addr_q;
  assign ROM_N_OE  = (state_q != READ);
  assign OUT_WORD  = word_q;
  assign OUT_VALID = (state_q == PRESENT);
  assign BUSY      = (state_q == READ) || (state_q == PRESENT);
  assign DONE      = (state_q == FINISH);

endmodule
